// File: rtl/sn_window_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2**LOG2_WIN accepted samples
// and publishes the unipolar count and the bipolar value 2*ones-WIN with a valid pulse.
module sn_window_decoder #(
    parameter int unsigned LOG2_WIN = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       sn_valid,
    input  logic                       sn_bit,
    output logic                       busy,
    output logic        [LOG2_WIN:0]   ones_count,
    output logic signed [LOG2_WIN+1:0] bipolar,
    output logic                       result_valid,
    output logic                       missed
);

    localparam int unsigned Win = 2 ** LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] SampLast = '1;

    typedef enum logic {StIdle, StCount} state_e;

    state_e                     state_q, state_d;
    logic        [LOG2_WIN:0]   acc_q, acc_d;
    logic        [LOG2_WIN-1:0] samp_q, samp_d;
    logic        [LOG2_WIN:0]   ones_q, ones_d;
    logic signed [LOG2_WIN+1:0] bip_q, bip_d;
    logic                       valid_q, valid_d;
    logic                       missed_q, missed_d;
    logic                       busy_q, busy_d;

    logic [LOG2_WIN:0] acc_sum;
    logic              window_done;

    assign acc_sum     = acc_q + (LOG2_WIN + 1)'(sn_bit);
    assign window_done = (state_q == StCount) && sn_valid && (samp_q == SampLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            samp_q   <= '0;
            ones_q   <= '0;
            bip_q    <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            samp_q   <= samp_d;
            ones_q   <= ones_d;
            bip_q    <= bip_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
            busy_q   <= busy_d;
        end
    end

    // start outranks window completion, so an abort never leaves COUNT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCount;
            StCount: if (!start && window_done && !continuous) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        samp_d   = samp_q;
        ones_d   = ones_q;
        bip_d    = bip_q;
        valid_d  = 1'b0;
        missed_d = missed_q;
        if (start) begin
            // The coincident sample is dropped in both states.
            acc_d    = '0;
            samp_d   = '0;
            missed_d = 1'b0;
        end else if (state_q == StIdle) begin
            if (sn_valid) missed_d = 1'b1;
        end else if (sn_valid) begin
            if (window_done) begin
                ones_d  = acc_sum;
                bip_d   = {acc_sum, 1'b0} - (LOG2_WIN + 2)'(Win);
                valid_d = 1'b1;
                acc_d   = '0;
                samp_d  = '0;
            end else begin
                acc_d  = acc_sum;
                samp_d = samp_q + LOG2_WIN'(1);
            end
        end
        busy_d = (state_d == StCount);
    end

    assign busy         = busy_q;
    assign ones_count   = ones_q;
    assign bipolar      = bip_q;
    assign result_valid = valid_q;
    assign missed       = missed_q;

endmodule

// File: tb/tb_sn_window_decoder.sv
// Bench for sn_window_decoder: queue-based window model checked every cycle, plus
// literal expectations from the directed scenarios.
module tb_sn_window_decoder;

    localparam int unsigned LOG2_WIN = 3;
    localparam int          WIN      = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic                       continuous = 1'b0;
    logic                       sn_valid = 1'b0;
    logic                       sn_bit = 1'b0;
    logic                       busy;
    logic        [LOG2_WIN:0]   ones_count;
    logic signed [LOG2_WIN+1:0] bipolar;
    logic                       result_valid;
    logic                       missed;

    int total = 0;
    int bad   = 0;

    sn_window_decoder #(.LOG2_WIN(LOG2_WIN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .sn_valid     (sn_valid),
        .sn_bit       (sn_bit),
        .busy         (busy),
        .ones_count   (ones_count),
        .bipolar      (bipolar),
        .result_valid (result_valid),
        .missed       (missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect accepted samples in a queue, sum them when the window fills.
    bit m_armed  = 1'b0;
    bit m_rv     = 1'b0;
    bit m_missed = 1'b0;
    int m_ones   = 0;
    int m_bip    = 0;
    bit win_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 1'b0; m_rv = 1'b0; m_missed = 1'b0; m_ones = 0; m_bip = 0;
            win_q.delete();
        end else begin
            m_rv = 1'b0;
            if (start) begin
                win_q.delete();
                m_armed  = 1'b1;
                m_missed = 1'b0;
            end else if (sn_valid) begin
                if (!m_armed) begin
                    m_missed = 1'b1;
                end else begin
                    win_q.push_back(sn_bit);
                    if (win_q.size() == WIN) begin
                        m_ones = 0;
                        foreach (win_q[i]) m_ones += int'(win_q[i]);
                        m_bip   = 2 * m_ones - WIN;
                        m_rv    = 1'b1;
                        m_armed = continuous;
                        win_q.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_armed));
        chk("ones_count", int'(ones_count), m_ones);
        chk("bipolar", int'(bipolar), m_bip);
        chk("result_valid", int'(result_valid), int'(m_rv));
        chk("missed", int'(missed), int'(m_missed));
    end

    // Inputs settle before the edge; returns just after that edge has been captured.
    task automatic step(input logic s, input logic v, input logic b);
        start = s; sn_valid = v; sn_bit = b;
        @(posedge clk);
        #1;
        start = 1'b0; sn_valid = 1'b0; sn_bit = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ones", int'(ones_count), 0);
        chk("rst_bip", int'(bipolar), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_missed", int'(missed), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0);

        // 1: eight ones
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1);
        chk("t1_no_early_pulse", int'(result_valid), 0);
        step(0, 1, 1);
        chk("t1_rv", int'(result_valid), 1);
        chk("t1_ones", int'(ones_count), 8);
        chk("t1_bip", int'(bipolar), 8);
        chk("t1_busy", int'(busy), 0);
        step(0, 0, 0);
        chk("t1_rv_single", int'(result_valid), 0);
        chk("t1_hold", int'(ones_count), 8);

        // 2: alternating pattern
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, (i % 2) == 0);
        chk("t2_ones", int'(ones_count), 4);
        chk("t2_bip", int'(bipolar), 0);

        // 3: gaps between samples
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            if (i == 7) chk("t3_no_pulse_in_gap", int'(result_valid), 0);
            step(0, 1, 1);
        end
        chk("t3_rv", int'(result_valid), 1);
        chk("t3_ones", int'(ones_count), 8);

        // 4: continuous back-to-back windows
        continuous = 1'b1;
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        chk("t4_rv0", int'(result_valid), 1);
        chk("t4_ones0", int'(ones_count), 0);
        chk("t4_bip0", int'(bipolar), -8);
        chk("t4_busy0", int'(busy), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        chk("t4_rv1", int'(result_valid), 1);
        chk("t4_ones1", int'(ones_count), 8);
        chk("t4_bip1", int'(bipolar), 8);
        chk("t4_busy1", int'(busy), 1);
        continuous = 1'b0;
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, i < 3);
        chk("t4_exit_ones", int'(ones_count), 3);
        chk("t4_exit_busy", int'(busy), 0);

        // 5: restart mid-window, coincident sample discarded
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        step(1, 1, 1);
        chk("t5_no_restart_pulse", int'(result_valid), 0);
        chk("t5_busy", int'(busy), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        chk("t5_rv", int'(result_valid), 1);
        chk("t5_ones", int'(ones_count), 0);
        chk("t5_bip", int'(bipolar), -8);

        // 6: missed flag, then reset mid-window
        step(0, 0, 0);
        step(0, 1, 1);
        chk("t6_missed", int'(missed), 1);
        step(0, 0, 0);
        chk("t6_missed_sticky", int'(missed), 1);
        step(1, 1, 1);
        chk("t6_missed_clr", int'(missed), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ones", int'(ones_count), 0);
        chk("t6_rst_bip", int'(bipolar), 0);
        chk("t6_rst_rv", int'(result_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        chk("t6_idle_after_rst", int'(ones_count), 0);
        chk("t6_missed_after_rst", int'(missed), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
